// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared encodings, state type and helpers for the load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Bit of the op field that selects zero-extension on loads
    localparam int OP_UNS_BIT = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_ERR  = 3'd4
    } lsu_state_t;

    // The reserved size code 11 behaves as a full word
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_W : sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Brief  : Combinational lane logic: load extraction/extension and sub-word
//          store merge into an existing memory word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  op_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [1:0] w_sz;
    logic [4:0] w_bsh;
    logic [4:0] w_hsh;
    logic [7:0] w_byte;
    logic [15:0] w_half;
    logic       w_sext;

    assign w_sz   = eff_size(op_i[1:0]);
    assign w_bsh  = {addr_lo_i, 3'b000};
    assign w_hsh  = {addr_lo_i[1], 4'b0000};
    assign w_byte = word_i[w_bsh +: 8];
    assign w_half = word_i[w_hsh +: 16];
    assign w_sext = ~op_i[OP_UNS_BIT];

    always_comb begin
        load_o  = word_i;
        merge_o = word_i;
        case (w_sz)
            SZ_B: begin
                load_o = {{24{w_sext & w_byte[7]}}, w_byte};
                merge_o[w_bsh +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                load_o = {{16{w_sext & w_half[15]}}, w_half};
                merge_o[w_hsh +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module : lsu
// Brief  : Load/store unit for a word-addressed memory; sub-word stores are
//          read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned
//          half/word accesses instead of silently aligning them.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_w_data,
    input  logic [31:0] m_r_data
);

    localparam int AW = DEPTH_LOG2 + 2;

    lsu_state_t     state_q, state_d;
    logic           we_q;
    logic [2:0]     op_q;
    logic [AW-1:0]  addr_q;
    logic [31:0]    data_q;

    logic           w_accept;
    logic [1:0]     w_req_sz;
    logic [AW-1:0]  w_addr_in;
    logic [31:0]    w_load;
    logic [31:0]    w_merge;
    logic           w_unused_addr;

    assign w_accept      = req_valid && (state_q == S_IDLE);
    assign w_req_sz      = eff_size(req_op[1:0]);
    assign w_unused_addr = ^req_addr[31:AW];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_addr_in = req_addr[AW-1:0];
`else
    // Misaligned low bits are dropped so the access lands on its natural boundary
    always_comb begin
        w_addr_in = req_addr[AW-1:0];
        if (w_req_sz == SZ_H) begin
            w_addr_in[0] = 1'b0;
        end else if (w_req_sz == SZ_W) begin
            w_addr_in[1:0] = 2'b00;
        end
    end
`endif

    lsu_align u_align (
        .word_i    (m_r_data),
        .wdata_i   (data_q),
        .addr_lo_i (addr_q[1:0]),
        .op_i      (op_q),
        .load_o    (w_load),
        .merge_o   (w_merge)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_we && (w_req_sz == SZ_W)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(w_req_sz, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end
`endif
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    rsp_valid = 1'b1;
                    rsp_data  = w_load;
                    state_d   = S_IDLE;
                end
            end
            S_WR: begin
                mem_write = 1'b1;
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m_addr   = {{(32-DEPTH_LOG2){1'b0}}, addr_q[AW-1:2]};
    assign m_w_data = (state_q == S_WR) ? data_q : '0;

    // data_q holds store data until CAP, then the merged word for WR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                we_q   <= req_we;
                op_q   <= req_op;
                addr_q <= w_addr_in;
                data_q <= req_wdata;
            end else if ((state_q == S_CAP) && we_q) begin
                data_q <= w_merge;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit between the CPU memory-access stage and the word-addressed data memory. Accepts byte/half/word load and store requests on a valid/ready handshake and converts byte addresses to word indices. Extracts and sign/zero-extends load data. Implements sub-word stores as read-modify-write, because the memory only supports full-word writes (written on negedge, read registered on posedge).

## Interface
- DEPTH_LOG2, 7: memory word-index width (128 words)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse: load data or store completion
- rsp_data  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned access flag, valid with rsp_valid
- mem_write  out  1  memory write enable
- m_addr  out  32  word index, zero-extended from req_addr[DEPTH_LOG2+1:2]
- m_w_data  out  32  memory write data
- m_r_data  in  32  memory read data, valid the cycle after m_addr is presented

## Operation
- States: IDLE, RD, CAP, WR, ERR.
- IDLE: req_ready=1. On accept, latch we/op/addr/wdata:
  - load or byte/half store -> RD
  - word store -> WR
  - misaligned (with macro) -> ERR
- RD: drive m_addr; mem_write=0 -> CAP.
- CAP: m_r_data is valid.
  - Load: rsp_valid=1, rsp_data = selected lane (byte addr[1:0], half addr[1]), sign-extended unless op[2]; -> IDLE.
  - Sub-word store: merge register <= m_r_data with lane replaced by wdata[7:0]/[15:0]; -> WR.
- WR: mem_write=1, m_w_data = merged word (or wdata for word store); rsp_valid=1, rsp_data=0 -> IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_data=0, no memory access -> IDLE.
- m_addr is held stable from RD through WR.
- req_ready=0 outside IDLE; req_valid is ignored while busy. No request is accepted in the rsp_valid cycle.
- Address bits above DEPTH_LOG2+1 are ignored; addresses wrap modulo 4·2^DEPTH_LOG2 bytes.
- op size 11 is treated as word.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, mem_write 0, m_addr 0, m_w_data 0, all latches 0.
- Latency from accept edge to rsp_valid cycle:
  - load: 2 cycles
  - word store: 1 cycle
  - sub-word store: 3 cycles
  - error: 1 cycle
- In WR, mem_write is high for exactly one full cycle. The write lands at that cycle's negedge.
- Reset mid-operation aborts immediately: no write issued, no rsp_valid. If asserted during WR, the memory is also in reset, so the write is lost.
- Read-after-write to the same word in back-to-back requests returns the new data, because the write completes at the WR negedge, before the next RD.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, goes to ERR
  - memory is untouched
- Undefined:
  - no ERR state; rsp_err tied 0
  - misaligned low bits are forced to 0 (half ignores addr[0], word ignores addr[1:0]) and the access proceeds normally

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W
  - unsigned bit index
  - state enum lsu_state_t
- Sub-module lsu_align, purely combinational, holds:
  - load lane extraction and extension (rdata, addr[1:0], op) -> 32-bit result
  - store merge (old word, wdata, addr[1:0], size) -> new word
- The top holds the FSM and registers.

## Test plan
- Word store 0xDEADBEEF @0x10, then LW @0x10 -> mem_write for one cycle at m_addr=4; load rsp_data=0xDEADBEEF two cycles after accept.
- Word 0x11223344 @0x20, then SB 0xAA @0x22 -> RD/CAP/WR sequence; word becomes 0x11AA3344; LBU @0x22 = 0x000000AA, LB = 0xFFFFFFAA.
- SH 0x8001 @0x06 over 0 -> word 1 = 0x80010000; LH @0x06 = 0xFFFF8001, LHU = 0x00008001.
- LW @0x201 with macro -> rsp_err=1, rsp_data=0, mem_write never asserts; without macro -> reads word 0 (wrap, low bits cleared), rsp_err=0.
- req_valid held high while busy -> only one accept per IDLE; rsp_valid pulses exactly once per request.
- rst asserted in the CAP cycle of a sub-word store -> outputs return to reset values asynchronously, no mem_write, next request is served normally.
